// File: rtl/encrypt_pkg.sv
// Shared types and constants for the Polybius-square stream encryptor:
// state encoding, the 5x5 square, the default key and the position lookup.
package encrypt_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_FLUSH = 2'd2,
        ST_DONE  = 2'd3
    } state_e;

    localparam int DEF_SEC_LEN = 9;

    // Square read row-major: rows MATEI, BCDFG, HKLNO, PQRSU, VWXYZ.
    localparam logic [0:24][7:0] SQUARE = "MATEIBCDFGHKLNOPQRSUVWXYZ";

    localparam logic [0:8][7:0] DEFAULT_KEY = "PARASCHIV";

    // Returns 10*row + col (1-based) of c in the square, 0 when absent.
    function automatic logic [7:0] sq_pos(input logic [7:0] c);
        logic [7:0] p;
        p = '0;
        for (int i = 0; i < 25; i++) begin
            if (SQUARE[i] == c) begin
                p = 8'((i / 5 + 1) * 10 + (i % 5) + 1);
            end
        end
        return p;
    endfunction

    // Default key character for a key index; repeats past its length.
    function automatic logic [7:0] default_key(input int idx);
        return DEFAULT_KEY[idx % DEF_SEC_LEN];
    endfunction

endpackage

// File: rtl/encrypt_stream_ctrl_if.sv
// Plaintext-in / ciphertext-out valid/ready streams of the encryptor.
// master = host/sink side, slave = the controller.
interface encrypt_stream_ctrl_if;

    logic       in_valid;
    logic       in_ready;
    logic [7:0] in_char;
    logic       out_valid;
    logic       out_ready;
    logic [7:0] out_char;
    logic       out_last;

    modport master (
        output in_valid,
        output in_char,
        output out_ready,
        input  in_ready,
        input  out_valid,
        input  out_char,
        input  out_last
    );

    modport slave (
        input  in_valid,
        input  in_char,
        input  out_ready,
        output in_ready,
        output out_valid,
        output out_char,
        output out_last
    );

endinterface

// File: rtl/encrypt_char.sv
// Combinational single-character Polybius encrypt: case fold, J->I,
// letter position plus key position, non-letters pass as byte + key pos.
module encrypt_char
    import encrypt_pkg::*;
(
    input  logic [7:0] in_char,
    input  logic [7:0] key_char,
    output logic [7:0] out_char
);

    logic       is_lower;
    logic       is_letter;
    logic [7:0] up;
    logic [7:0] base;
    logic [7:0] kp;

    // Fold, substitute and add the key position with 8-bit wrap.
    always_comb begin
        is_lower  = (in_char >= 8'h61) && (in_char <= 8'h7a);
        up        = is_lower ? (in_char - 8'h20) : in_char;
        if (up == 8'h4a) begin
            up = 8'h49;
        end
        is_letter = (up >= 8'h41) && (up <= 8'h5a);
        kp        = sq_pos(key_char);
        base      = is_letter ? sq_pos(up) : in_char;
        out_char  = base + kp;
    end

endmodule

// File: rtl/encrypt_stream_ctrl.sv
// Byte-serial encrypt sequencer with registered ciphertext output.
// ENCRYPT_KEY_LOAD_EN adds a writable key register file (IDLE-only writes).
module encrypt_stream_ctrl
    import encrypt_pkg::*;
#(
    parameter int MAX_LEN = 64,
    parameter int SEC_LEN = DEF_SEC_LEN,
    parameter int LEN_W   = $clog2(MAX_LEN + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [LEN_W-1:0] msg_len,
    output logic             busy,
    output logic             done,
`ifdef ENCRYPT_KEY_LOAD_EN
    input  logic                       key_we,
    input  logic [$clog2(SEC_LEN)-1:0] key_idx,
    input  logic [7:0]                 key_char,
`endif
    encrypt_stream_ctrl_if.slave strm
);

    localparam int KW = (SEC_LEN > 1) ? $clog2(SEC_LEN) : 1;

    localparam logic [1:0] IDLE  = ST_IDLE;
    localparam logic [1:0] RUN   = ST_RUN;
    localparam logic [1:0] FLUSH = ST_FLUSH;
    localparam logic [1:0] DONE  = ST_DONE;

    localparam logic [LEN_W-1:0] MAX_L    = LEN_W'(MAX_LEN);
    localparam logic [KW-1:0]    KEY_LAST = KW'(SEC_LEN - 1);

    logic [1:0]       state;
    logic [LEN_W-1:0] remaining;
    logic [LEN_W-1:0] len_clamped;
    logic [KW-1:0]    kidx;
    logic [7:0]       cur_key;
    logic [7:0]       enc_char;
    logic             accept;
    logic             out_fire;
    logic             last_in;

    logic             ov_q;
    logic [7:0]       oc_q;
    logic             ol_q;

`ifdef ENCRYPT_KEY_LOAD_EN
    logic [7:0] key_q [SEC_LEN];

    // Key register file: reloads the default key on reset, host writes in IDLE.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < SEC_LEN; i++) begin
                key_q[i] <= default_key(i);
            end
        end else if (key_we && (state == IDLE) &&
                     (32'(key_idx) < SEC_LEN)) begin
            key_q[key_idx] <= key_char;
        end
    end

    assign cur_key = key_q[kidx];
`else
    assign cur_key = default_key(int'(kidx));
`endif

    assign len_clamped = (msg_len > MAX_L) ? MAX_L : msg_len;
    assign last_in     = (remaining == LEN_W'(1));

    assign strm.in_ready = (state == RUN) && (remaining != '0) &&
                           (!ov_q || strm.out_ready);

    assign accept   = strm.in_valid && strm.in_ready;
    assign out_fire = ov_q && strm.out_ready;

    assign busy = (state != IDLE);
    assign done = (state == DONE);

    assign strm.out_valid = ov_q;
    assign strm.out_char  = oc_q;
    assign strm.out_last  = ol_q;

    encrypt_char u_enc (
        .in_char  (strm.in_char),
        .key_char (cur_key),
        .out_char (enc_char)
    );

    // Message sequencing: length countdown, key index walk, state moves.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            remaining <= '0;
            kidx      <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (start) begin
                        kidx      <= '0;
                        remaining <= len_clamped;
                        state     <= (len_clamped == '0) ? DONE : RUN;
                    end
                end
                RUN: begin
                    if (accept) begin
                        remaining <= remaining - 1'b1;
                        kidx      <= (kidx == KEY_LAST) ? '0 : kidx + 1'b1;
                        if (last_in) begin
                            state <= FLUSH;
                        end
                    end
                end
                FLUSH: begin
                    if (out_fire) begin
                        state <= DONE;
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    // Output holding register: a new byte overwrites, a bare handshake empties.
    always_ff @(posedge clk) begin
        if (rst) begin
            ov_q <= 1'b0;
            oc_q <= '0;
            ol_q <= 1'b0;
        end else if (accept) begin
            ov_q <= 1'b1;
            oc_q <= enc_char;
            ol_q <= last_in;
        end else if (out_fire) begin
            ov_q <= 1'b0;
            ol_q <= 1'b0;
        end
    end

endmodule

// File: tb/tb_encrypt_stream_ctrl.sv
// Directed + randomized bench for encrypt_stream_ctrl with a string-based
// reference cipher model and per-cycle handshake checking.
module tb_encrypt_stream_ctrl;

    localparam int MAX_LEN = 64;
    localparam int LEN_W   = 7;

    typedef logic [7:0] bq_t[$];

    logic             clk = 1'b0;
    logic             rst;
    logic             start;
    logic [LEN_W-1:0] msg_len;
    logic             busy;
    logic             done;

    int checks = 0;
    int errors = 0;

    encrypt_stream_ctrl_if sif ();

    encrypt_stream_ctrl #(
        .MAX_LEN (MAX_LEN)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .start   (start),
        .msg_len (msg_len),
        .busy    (busy),
        .done    (done),
        .strm    (sif)
    );

    always #5 clk = ~clk;

    initial begin
        #900000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    function automatic int ref_pos(input logic [7:0] c);
        string sq;
        sq = "MATEIBCDFGHKLNOPQRSUVWXYZ";
        for (int i = 0; i < 25; i++) begin
            if (sq[i] == c) return (i / 5 + 1) * 10 + (i % 5) + 1;
        end
        return 0;
    endfunction

    // Cipher of one character at running character number k.
    function automatic logic [7:0] ref_enc(input logic [7:0] c, input int k);
        string key;
        logic [7:0] u;
        int kp;
        int v;
        key = "PARASCHIV";
        kp = ref_pos(key[k % 9]);
        u = c;
        if (u >= 8'h61 && u <= 8'h7a) u = u - 8'd32;
        if (u == 8'h4a) u = 8'h49;
        if (u >= 8'h41 && u <= 8'h5a) v = ref_pos(u) + kp;
        else v = int'(c) + kp;
        return v[7:0];
    endfunction

    function automatic bq_t str2q(input string s);
        bq_t q;
        for (int i = 0; i < s.len(); i++) q.push_back(s[i]);
        return q;
    endfunction

    // mode 0: always valid/ready; 1: random valid/ready plus a stray start;
    // 2: always valid, out_ready low for 4 cycles mid-message.
    task automatic run_msg(input bq_t pt, input int len, input int mode,
                           output bq_t got);
        bq_t        exp_q;
        int         n;
        int         acc;
        int         oi;
        int         last_hs;
        int         first_acc;
        int         first_ov;
        bit         seen;
        bit         hold;
        bit         exp_ir;
        bit         exp_done;
        logic [7:0] h_char;
        logic       h_last;
        got = {};
        n = (len > MAX_LEN) ? MAX_LEN : len;
        for (int i = 0; i < n; i++) exp_q.push_back(ref_enc(pt[i], i));
        @(negedge clk);
        start = 1'b1;
        msg_len = LEN_W'(len);
        sif.in_valid = 1'b0;
        sif.out_ready = 1'b1;
        @(negedge clk);
        start = 1'b0;
        acc = 0;
        oi = 0;
        last_hs = -100;
        first_acc = -1;
        first_ov = -1;
        seen = 1'b0;
        hold = 1'b0;
        h_char = '0;
        h_last = 1'b0;
        for (int t = 0; t < 4000 && !seen; t++) begin
            start = (mode == 1 && t == 2);
            if (mode == 1 && t == 2) msg_len = LEN_W'(3);
            sif.in_valid = (acc < n) &&
                           (mode != 1 || $urandom_range(0, 3) != 0);
            sif.in_char = (acc < n) ? pt[acc] : 8'($urandom);
            case (mode)
                0: sif.out_ready = 1'b1;
                1: sif.out_ready = ($urandom_range(0, 2) != 0);
                default: sif.out_ready = !(t >= 3 && t < 7);
            endcase
            #1;
            exp_ir = (acc < n) && (!sif.out_valid || sif.out_ready);
            chk("in_ready", 32'(sif.in_ready), 32'(exp_ir));
            if (hold) begin
                chk("hold_valid", 32'(sif.out_valid), 32'd1);
                chk("hold_char", 32'(sif.out_char), 32'(h_char));
                chk("hold_last", 32'(sif.out_last), 32'(h_last));
            end
            exp_done = (oi == n) && (t == last_hs + 1);
            chk("done", 32'(done), 32'(exp_done));
            chk("busy", 32'(busy), 32'd1);
            seen = exp_done;
            if (first_ov < 0 && sif.out_valid) begin
                first_ov = t;
                chk("latency", 32'(t), 32'(first_acc + 1));
            end
            if (sif.in_valid && sif.in_ready) begin
                if (first_acc < 0) first_acc = t;
                acc++;
            end
            if (sif.out_valid && sif.out_ready) begin
                if (oi < n) begin
                    chk("out_char", 32'(sif.out_char), 32'(exp_q[oi]));
                    chk("out_last", 32'(sif.out_last), 32'(oi == n - 1));
                    got.push_back(sif.out_char);
                end else begin
                    chk("extra_byte", 32'(oi), 32'(n));
                end
                if (mode == 0 && oi > 0) chk("back_to_back", 32'(t), 32'(last_hs + 1));
                last_hs = t;
                oi++;
            end
            hold = sif.out_valid && !sif.out_ready;
            h_char = sif.out_char;
            h_last = sif.out_last;
            if (!seen) @(negedge clk);
        end
        chk("finished", 32'(seen), 32'd1);
        sif.in_valid = 1'b0;
        @(negedge clk);
        #1;
        chk("idle_busy", 32'(busy), 32'd0);
        chk("idle_done", 32'(done), 32'd0);
    endtask

    initial begin
        bq_t got;
        bq_t pt;
        int  acc;
        int  len;
        int  exp5[5];
        int  exp10[10];
        exp5  = '{72, 26, 76, 45, 79};
        exp10 = '{52, 23, 54, 23, 55, 33, 42, 26, 62, 52};

        rst = 1'b1;
        start = 1'b0;
        msg_len = '0;
        sif.in_valid = 1'b0;
        sif.in_char = '0;
        sif.out_ready = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_in_ready", 32'(sif.in_ready), 32'd0);
        chk("rst_out_valid", 32'(sif.out_valid), 32'd0);
        chk("rst_out_char", 32'(sif.out_char), 32'd0);
        chk("rst_out_last", 32'(sif.out_last), 32'd0);
        rst = 1'b0;

        run_msg(str2q("HELLO"), 5, 0, got);
        chk("hello_count", 32'(got.size()), 32'd5);
        for (int i = 0; i < 5; i++) chk("hello_byte", 32'(got[i]), 32'(exp5[i]));

        run_msg(str2q("MMMMMMMMMM"), 10, 0, got);
        chk("m10_count", 32'(got.size()), 32'd10);
        for (int i = 0; i < 10; i++) chk("m10_byte", 32'(got[i]), 32'(exp10[i]));

        pt = str2q("a XJjz?9");
        pt.push_back(8'hFF);
        run_msg(pt, 9, 0, got);
        chk("special_a", 32'(got[0]), 32'd53);
        chk("special_space", 32'(got[1]), 32'd44);
        chk("special_ff", 32'(got[8]), 32'd50);

        run_msg(str2q("STALLING"), 8, 2, got);
        chk("stall_count", 32'(got.size()), 32'd8);

        @(negedge clk);
        start = 1'b1;
        msg_len = '0;
        #1;
        chk("zero_busy_pre", 32'(busy), 32'd0);
        @(negedge clk);
        start = 1'b0;
        #1;
        chk("zero_done", 32'(done), 32'd1);
        chk("zero_busy", 32'(busy), 32'd1);
        chk("zero_out_valid", 32'(sif.out_valid), 32'd0);
        @(negedge clk);
        #1;
        chk("zero_done_end", 32'(done), 32'd0);
        chk("zero_idle", 32'(busy), 32'd0);

        for (int m = 0; m < 4; m++) begin
            len = (m == 3) ? 100 : $urandom_range(1, 20);
            pt = {};
            for (int i = 0; i < len; i++) begin
                case ($urandom_range(0, 2))
                    0: pt.push_back(8'($urandom_range(65, 90)));
                    1: pt.push_back(8'($urandom_range(97, 122)));
                    default: pt.push_back(8'($urandom_range(0, 255)));
                endcase
            end
            run_msg(pt, len, 1, got);
            chk("rand_count", 32'(got.size()),
                32'((len > MAX_LEN) ? MAX_LEN : len));
        end

        @(negedge clk);
        start = 1'b1;
        msg_len = LEN_W'(8);
        @(negedge clk);
        start = 1'b0;
        acc = 0;
        for (int t = 0; t < 100 && acc < 3; t++) begin
            sif.in_valid = 1'b1;
            sif.in_char = 8'h41 + 8'(acc);
            sif.out_ready = 1'b1;
            #1;
            if (sif.in_valid && sif.in_ready) acc++;
            if (acc < 3) @(negedge clk);
        end
        chk("abort_accepts", 32'(acc), 32'd3);
        @(negedge clk);
        rst = 1'b1;
        sif.in_valid = 1'b0;
        @(negedge clk);
        #1;
        chk("abort_busy", 32'(busy), 32'd0);
        chk("abort_done", 32'(done), 32'd0);
        chk("abort_in_ready", 32'(sif.in_ready), 32'd0);
        chk("abort_out_valid", 32'(sif.out_valid), 32'd0);
        chk("abort_out_char", 32'(sif.out_char), 32'd0);
        chk("abort_out_last", 32'(sif.out_last), 32'd0);
        rst = 1'b0;
        repeat (3) begin
            @(negedge clk);
            #1;
            chk("abort_no_done", 32'(done), 32'd0);
            chk("abort_idle", 32'(busy), 32'd0);
        end

        run_msg(str2q("MM"), 2, 0, got);
        chk("fresh_key0", 32'(got[0]), 32'd52);
        chk("fresh_key1", 32'(got[1]), 32'd23);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
